// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported RAM between two requesters: port 0 (instruction
// fetch) and port 1 (load/store). One transaction is in flight at a time.
// Ties are broken round-robin, so a continuously requesting port waits at
// most one foreign transaction before being served.
//
// Transaction flow:
//   IDLE  -> sample requests, latch the winner's we/addr/wdata
//   ISSUE -> one-cycle registered mem_rd or mem_wr strobe
//   WAIT  -> reads only, RD_LAT cycles; mem_rdata captured on exit
//   RESP  -> one-cycle ack to the granted port
//
// Parameters:
//   ADDR_W  memory word-address width
//   DATA_W  data width
//   RD_LAT  cycles from the mem_rd strobe to valid mem_rdata (1..7)
//
// Ports:
//   clk, clr_n              clock, asynchronous active-low reset
//   req0/1, we0/1           request and write-enable per port
//   addr0/1, wdata0/1       address and write data per port
//   ack0/1                  one-cycle completion pulse per port
//   rdata0/1                read data, held until that port's next read
//   mem_rd, mem_wr          one-cycle strobes to the RAM
//   mem_addr, mem_wdata     registered address/data to the RAM
//   mem_rdata               read data from the RAM
//   busy                    high whenever the FSM is not in IDLE
//   gnt                     port owning the current or last transaction
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // WAIT lasts RD_LAT cycles: load RD_LAT-1 and leave when the count is 0.
    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    state_t                       state_reg;
    logic [2:0]                   cnt_reg;
    logic                         we_reg;
    logic                         gnt_reg;
    logic                         last_gnt_reg;
    logic                         mem_rd_reg;
    logic                         mem_wr_reg;
    logic [ADDR_W-1:0]            mem_addr_reg;
    logic [DATA_W-1:0]            mem_wdata_reg;
    logic [1:0]                   ack_reg;
    logic [1:0][DATA_W-1:0]       rdata_reg;

    logic [1:0]                   req_vec;
    logic                         win_next;
    logic                         win_we_next;
    logic [ADDR_W-1:0]            win_addr_next;
    logic [DATA_W-1:0]            win_wdata_next;

    assign req_vec = {req1, req0};

    // Winner selection: a lone request wins outright; on a tie the port that
    // did not own the previous transaction wins.
    always_comb begin
        win_next = req_vec[1];
        if (req_vec == 2'b11) begin
            win_next = ~last_gnt_reg;
        end
        win_we_next    = win_next ? we1    : we0;
        win_addr_next  = win_next ? addr1  : addr0;
        win_wdata_next = win_next ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            we_reg        <= 1'b0;
            gnt_reg       <= 1'b0;
            last_gnt_reg  <= 1'b1;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            ack_reg       <= 2'b00;
            rdata_reg     <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses: low unless set below.
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            ack_reg    <= 2'b00;

            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        gnt_reg       <= win_next;
                        last_gnt_reg  <= win_next;
                        we_reg        <= win_we_next;
                        // Address/data are registered here so they are valid
                        // alongside the strobe in ISSUE and frozen afterwards.
                        mem_addr_reg  <= win_addr_next;
                        mem_wdata_reg <= win_wdata_next;
                        mem_rd_reg    <= ~win_we_next;
                        mem_wr_reg    <= win_we_next;
                        state_reg     <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (we_reg) begin
                        ack_reg[gnt_reg] <= 1'b1;
                        state_reg        <= RESP;
                    end else begin
                        cnt_reg   <= WAIT_LOAD;
                        state_reg <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt_reg == 3'd0) begin
                        rdata_reg[gnt_reg] <= mem_rdata;
                        ack_reg[gnt_reg]   <= 1'b1;
                        state_reg          <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end

                RESP: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack_reg[0];
    assign ack1      = ack_reg[1];
    assign rdata0    = rdata_reg[0];
    assign rdata1    = rdata_reg[1];
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = (state_reg != IDLE);
    assign gnt       = gnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances share the same inputs:
// dut_a with RD_LAT=1 and dut_b with RD_LAT=3, each with its own RAM model.
// 'sel' chooses which instance the checks observe; both are reset before the
// RD_LAT=3 section so they start in step.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        req0, req1, we0, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        sel;

    logic        a_ack0, a_ack1, a_mem_rd, a_mem_wr, a_busy, a_gnt;
    logic [31:0] a_rdata0, a_rdata1, a_mem_wdata, a_mem_rdata;
    logic [8:0]  a_mem_addr;
    logic        b_ack0, b_ack1, b_mem_rd, b_mem_wr, b_busy, b_gnt;
    logic [31:0] b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata;
    logic [8:0]  b_mem_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int excl_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) dut_a (
        .clk(clk), .clr_n(clr_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .gnt(a_gnt)
    );

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) dut_b (
        .clk(clk), .clr_n(clr_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .gnt(b_gnt)
    );

    // RAM models: data is valid exactly RD_LAT cycles after the strobe and is
    // a poison pattern otherwise, so an early or late capture is visible.
    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [0:2];

    always @(posedge clk) begin
        if (a_mem_wr) mem_a[a_mem_addr] <= a_mem_wdata;
        pipe_a <= a_mem_rd ? mem_a[a_mem_addr] : 32'h0BAD0BAD;
        if (b_mem_wr) mem_b[b_mem_addr] <= b_mem_wdata;
        pipe_b[0] <= b_mem_rd ? mem_b[b_mem_addr] : 32'h0BAD0BAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if ((a_mem_rd && a_mem_wr) || (b_mem_rd && b_mem_wr)) excl_err <= excl_err + 1;
    end

    assign a_mem_rdata = pipe_a;
    assign b_mem_rdata = pipe_b[2];

    // Observed instance
    wire        s_ack0      = sel ? b_ack0      : a_ack0;
    wire        s_ack1      = sel ? b_ack1      : a_ack1;
    wire        s_mem_rd    = sel ? b_mem_rd    : a_mem_rd;
    wire        s_mem_wr    = sel ? b_mem_wr    : a_mem_wr;
    wire        s_busy      = sel ? b_busy      : a_busy;
    wire        s_gnt       = sel ? b_gnt       : a_gnt;
    wire [31:0] s_rdata0    = sel ? b_rdata0    : a_rdata0;
    wire [31:0] s_rdata1    = sel ? b_rdata1    : a_rdata1;
    wire [31:0] s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
    wire [8:0]  s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clr_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick;
        clr_n = 1'b1;
        tick;
        check_eq("rst_busy",      s_busy,      0);
        check_eq("rst_gnt",       s_gnt,       0);
        check_eq("rst_ack0",      s_ack0,      0);
        check_eq("rst_ack1",      s_ack1,      0);
        check_eq("rst_mem_rd",    s_mem_rd,    0);
        check_eq("rst_mem_wr",    s_mem_wr,    0);
        check_eq("rst_mem_addr",  s_mem_addr,  0);
        check_eq("rst_mem_wdata", s_mem_wdata, 0);
        check_eq("rst_rdata0",    s_rdata0,    0);
        check_eq("rst_rdata1",    s_rdata1,    0);
        $display("reset: released, outputs checked");
    endtask

    // One transaction starting in an IDLE cycle (cycle 0 = now). Optionally
    // scrambles the port inputs right after the grant.
    task automatic txn(input bit port, input bit we, input logic [8:0] addr,
                       input logic [31:0] wd, input int exp_cyc,
                       input logic [31:0] exp_rd, input bit perturb);
        int strobe_cyc = -1;
        int ack_cyc    = -1;
        int strobes    = 0;
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
        else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (s_mem_rd || s_mem_wr) begin
                strobes++;
                if (strobe_cyc < 0) begin
                    strobe_cyc = c;
                    check_eq("strobe_kind", s_mem_wr, we);
                    check_eq("strobe_addr", s_mem_addr, addr);
                    if (we) check_eq("strobe_wdata", s_mem_wdata, wd);
                end
            end
            if (perturb && c == 1) begin
                if (port) begin addr1 = 9'h1FF; we1 = ~we; wdata1 = ~wd; end
                else      begin addr0 = 9'h1FF; we0 = ~we; wdata0 = ~wd; end
            end
            if (port ? s_ack1 : s_ack0) begin
                ack_cyc = c;
                check_eq("ack_other", port ? s_ack0 : s_ack1, 0);
                check_eq("ack_gnt", s_gnt, port);
                check_eq("addr_held", s_mem_addr, addr);
                if (!we) check_eq("rdata", port ? s_rdata1 : s_rdata0, exp_rd);
                if (port) req1 = 1'b0; else req0 = 1'b0;
                break;
            end
        end
        if (ack_cyc < 0) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        check_eq("strobe_cyc", strobe_cyc, 1);
        check_eq("strobe_count", strobes, 1);
        check_eq("ack_cyc", ack_cyc, exp_cyc);
        $display("txn: port=%0d we=%0d addr=0x%03h wdata=0x%08h ack_cyc=%0d rdata=0x%08h",
                 port, we, addr, wd, ack_cyc, port ? s_rdata1 : s_rdata0);
        tick;
        check_eq("idle_after", s_busy, 0);
    endtask

    int ack_at [0:3];
    int ack_pt [0:3];
    int n_ack;

    initial begin
        sel = 1'b0;
        clr_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[9'h010] = 32'hA0A00010;
        mem_a[9'h020] = 32'hB0B00020;
        mem_a[9'h005] = 32'h55AA55AA;
        mem_a[9'h1FF] = 32'hFFFF0000;
        mem_b[9'h040] = 32'hDEADBEEF;

        do_reset;

        // Port 1 write then read back
        txn(1'b1, 1'b1, 9'h001, 32'h12345678, 2, 32'h0, 1'b0);
        txn(1'b1, 1'b0, 9'h001, 32'h0, 3, 32'h12345678, 1'b0);

        // Simultaneous continuous reads from reset: grants alternate 0,1,0,1
        do_reset;
        n_ack = 0;
        req0 = 1; we0 = 0; addr0 = 9'h010;
        req1 = 1; we1 = 0; addr1 = 9'h020;
        for (int c = 1; c <= 15; c++) begin
            tick;
            if ((s_ack0 || s_ack1) && n_ack < 4) begin
                ack_at[n_ack] = c;
                ack_pt[n_ack] = s_ack1 ? 1 : 0;
                $display("rr: ack port=%0d cycle=%0d gnt=%0d", ack_pt[n_ack], c, s_gnt);
                n_ack++;
            end
            if (c == 15) begin req0 = 0; req1 = 0; end
        end
        check_eq("rr_n_ack", n_ack, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("rr_ack_cyc", ack_at[i], 3 + 4 * i);
            check_eq("rr_ack_port", ack_pt[i], i % 2);
        end
        check_eq("rr_rdata0", s_rdata0, 32'hA0A00010);
        check_eq("rr_rdata1", s_rdata1, 32'hB0B00020);
        tick;

        // Latched fields: inputs scrambled after grant are ignored
        txn(1'b0, 1'b0, 9'h005, 32'h0, 3, 32'h55AA55AA, 1'b1);

        // Back-to-back: port 0 holds req through its ack
        n_ack = 0;
        req0 = 1; we0 = 1; addr0 = 9'h030; wdata0 = 32'h11110030;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (s_ack0 && n_ack < 4) begin
                ack_at[n_ack] = c;
                $display("b2b: ack0 cycle=%0d", c);
                n_ack++;
                addr0 = 9'h031; wdata0 = 32'h22220031;
                if (n_ack == 2) req0 = 0;
            end
        end
        req0 = 0;
        check_eq("b2b_n_ack", n_ack, 2);
        check_eq("b2b_ack1_cyc", ack_at[0], 2);
        check_eq("b2b_ack2_cyc", ack_at[1], 5);
        txn(1'b0, 1'b0, 9'h031, 32'h0, 3, 32'h22220031, 1'b0);
        txn(1'b0, 1'b0, 9'h030, 32'h0, 3, 32'h11110030, 1'b0);

        // Reset pulse during WAIT drops the transaction
        req1 = 1; we1 = 0; addr1 = 9'h001;
        tick;
        tick;
        check_eq("wait_busy", s_busy, 1);
        clr_n = 0;
        #1;
        check_eq("wait_rst_busy", s_busy, 0);
        check_eq("wait_rst_mem_rd", s_mem_rd, 0);
        check_eq("wait_rst_gnt", s_gnt, 0);
        req1 = 0;
        tick;
        clr_n = 1;
        n_ack = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (s_ack0 || s_ack1) n_ack++;
        end
        check_eq("wait_rst_no_ack", n_ack, 0);
        $display("reset-in-wait: acks after reset=%0d", n_ack);

        // RD_LAT=3 instance
        do_reset;
        sel = 1'b1;
        txn(1'b0, 1'b0, 9'h040, 32'h0, 5, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 1'b1, 9'h041, 32'h00000001, 2, 32'h0, 1'b0);
        check_eq("lat3_rdata0_held", s_rdata0, 32'hDEADBEEF);

        check_eq("rd_wr_exclusive", excl_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer sitting in front of the single-ported RAM_Reg memory. It shares that memory between the instruction-fetch requester (port 0) and the load/store requester (port 1): it accepts one request at a time, issues one-cycle Read/Write strobes with registered address and data, waits out the memory read latency, and returns the read data with a one-cycle acknowledge. Arbitration is round-robin, so neither port can starve the other.

## Interface
- ADDR_W, 9, memory word-address width.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from the registered Read strobe to valid memory data. Legal range is 1..7.

- clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  port request; held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read; qualified by req.
- addr0 / addr1  in  ADDR_W  port address.
- wdata0 / wdata1  in  DATA_W  port write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  read data; valid during ack and held until the port's next read completes.
- mem_rd  out  1  Read strobe to RAM_Reg.
- mem_wr  out  1  Write strobe to RAM_Reg.
- mem_addr  out  ADDR_W  address to RAM_Reg, zero-extended to 32 bits at the RAM instance.
- mem_wdata  out  DATA_W  data to RAM_Reg Data_Signal.
- mem_rdata  in  DATA_W  RAM_Reg BusMuxIn.
- busy  out  1  high in every state except IDLE.
- gnt  out  1  port that owns the current or last transaction.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. IDLE is the reset state.
- **IDLE**
  - Samples req0 and req1.
  - If neither is high, it stays in IDLE.
  - If exactly one is high, that port wins.
  - If both are high, the port not granted last time wins. last_gnt resets to 1, so port 0 wins the first tie.
  - On a win, the FSM latches the winner's we, addr and wdata, sets gnt and last_gnt, and goes to ISSUE.
- **ISSUE**
  - Lasts exactly 1 cycle.
  - mem_rd = ~we_latched and mem_wr = we_latched, driven from registers with the latched address and data.
  - Next state is WAIT for a read, RESP for a write.
- **WAIT** (reads only)
  - Lasts RD_LAT cycles, timed by a 3-bit down-counter loaded with RD_LAT-1 on entry.
  - On the edge that leaves WAIT, mem_rdata is captured into rdata[gnt]. Then the FSM goes to RESP.
- **RESP**
  - ack[gnt] is high for 1 cycle, then the FSM returns to IDLE.
  - For a write, rdata is left unchanged.
- Request handling:
  - Requests are sampled only in IDLE.
  - Latched fields are frozen for the whole transaction, so changes on addr, we, wdata or req after the grant are ignored.
  - Dropping req after the grant does not cancel the transaction.
  - A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is a new transaction.
- Outputs:
  - mem_addr and mem_wdata hold their last latched values outside ISSUE.
  - mem_rd and mem_wr are never high together, and each is high for at most 1 cycle per transaction.
- Reset (clr_n low, at any time including mid-transaction):
  - State goes to IDLE immediately and asynchronously.
  - The in-flight transaction is dropped and no ack is issued.
  - Reset values: mem_rd 0, mem_wr 0, ack0 0, ack1 0, mem_addr 0, mem_wdata 0, rdata0 0, rdata1 0, busy 0, gnt 0, last_gnt 1.

## Timing
- Cycle 0 is the IDLE cycle in which the winning req is sampled.
- Read: ISSUE in cycle 1, WAIT in cycles 2..1+RD_LAT, ack in cycle 2+RD_LAT. With RD_LAT=1, ack is in cycle 3.
- Write: ISSUE in cycle 1 (mem_wr high), ack in cycle 2.
- The next grant is decided no earlier than the IDLE cycle that follows RESP.
- Maximum throughput:
  - one read per 3+RD_LAT cycles;
  - one write per 3 cycles.
- Worst-case wait for a continuously requesting port is one foreign transaction plus its own.

## Test plan
- **Reset:** hold clr_n=0 for 3 cycles, then release.
  - All outputs read 0; busy is 0.
  - Pulse clr_n low during WAIT: the FSM returns to IDLE, no ack is issued, and mem_rd is 0.
- **Single write then read on port 1:** write addr 0x001 with data 0x12345678, then read 0x001.
  - mem_wr is high 1 cycle in cycle 1; ack1 in cycle 2.
  - Read: mem_rd in cycle 1, ack1 in cycle 3 with rdata1=0x12345678.
- **Simultaneous requests from reset:** req0 reads 0x010 and req1 reads 0x020, both held continuously.
  - Grants alternate 0,1,0,1.
  - The ack pattern repeats every 4 cycles.
- **Latched fields:** change addr0 to 0x1FF one cycle after the grant.
  - mem_addr still shows the original address.
  - rdata0 comes from the original location.
- **RD_LAT=3 instance:** a read of a preloaded word 0xDEADBEEF acks in cycle 5 with the correct data.
  - rdata0 holds that value through a later port-0 write.
- **Back-to-back:** port 0 keeps req high through its ack.
  - A second transaction is granted in the following IDLE.
  - mem_rd and mem_wr are never high together across the whole run.
